tinyalu_core_p: RTL

- Parametrised, synthesisable ALU core.
- Next generation of the tinyalu datapath: configurable operand width and multiply latency, an error flag, and an optional iterative divider.
- Same start/done handshake and 3-bit opcode interface as the existing tinyalu BFM, so that BFM drives it unchanged at WIDTH=8.
- Sits directly behind the test-bench BFM or a bus adapter.

---
 rtl/tinyalu_core_p.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/tinyalu_core_p.sv
// tinyalu_core_p: parametrised ALU core with a start/done handshake.
// Operations: no_op, add, and, xor, multi-cycle mul, rst_op. Opcode 110 is
// always illegal (done with err=1, result=0).
// Optional feature macro TINYALU_DIV_EN: enables opcode 101 as an unsigned
// restoring divider (one quotient bit per cycle). Without it, 101 is illegal.
module tinyalu_core_p #(
    parameter int WIDTH   = 8,
    parameter int MUL_LAT = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [2:0]           op,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 err,
    output logic                 busy
);

    localparam int RW      = 2 * WIDTH;
    localparam int CNT_MAX = (MUL_LAT > WIDTH + 1) ? MUL_LAT : WIDTH + 1;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_RST = 3'b111;
`ifdef TINYALU_DIV_EN
    localparam logic [2:0] OP_DIV = 3'b101;
`endif

    typedef enum logic [1:0] {IDLE, EXEC, DONE, HOLD} state_t;

    state_t          state, state_next;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]      op_q;
    logic [CW-1:0]   cnt, cnt_load;
    logic            accept_cmd, clear_cmd, finish;
    logic [RW-1:0]   exec_result;
    logic            exec_err;
`ifdef TINYALU_DIV_EN
    // Remainder of the restoring divider; a_q doubles as the quotient shifter.
    logic [WIDTH-1:0] rem_q, rem_step;
    logic [WIDTH:0]   trial;
    logic             trial_ge;
`endif

    assign done = (state == DONE);
    assign busy = (state != IDLE);

    // State register; an asynchronous reset abandons any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state decode and command accept/clear/finish strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_next = state;
        accept_cmd = 1'b0;
        clear_cmd  = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && op == OP_RST) begin
                    clear_cmd  = 1'b1;
                    state_next = HOLD;
                end else if (start && op != OP_NOP) begin
                    accept_cmd = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (cnt == '0) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = start ? HOLD : IDLE;
            HOLD:    if (!start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Number of extra EXEC cycles beyond the first, chosen at accept time.
    always_comb begin
        cnt_load = '0;
        if (op == OP_MUL) cnt_load = CW'(MUL_LAT - 1);
`ifdef TINYALU_DIV_EN
        if (op == OP_DIV) cnt_load = CW'(WIDTH);
`endif
    end

`ifdef TINYALU_DIV_EN
    // One restoring-divide step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        trial    = {rem_q, a_q[WIDTH-1]};
        trial_ge = (trial >= {1'b0, b_q});
        rem_step = trial_ge ? WIDTH'(trial - {1'b0, b_q}) : WIDTH'(trial);
    end
`endif

    // Final result/err selection from the latched opcode and operands.
    always_comb begin
        exec_result = '0;
        exec_err    = 1'b0;
        case (op_q)
            OP_ADD: exec_result = RW'({1'b0, a_q} + {1'b0, b_q});
            OP_AND: exec_result = RW'(a_q & b_q);
            OP_XOR: exec_result = RW'(a_q ^ b_q);
            OP_MUL: exec_result = RW'(a_q) * RW'(b_q);
`ifdef TINYALU_DIV_EN
            OP_DIV: begin
                exec_result = {rem_q, a_q};
                exec_err    = (b_q == '0);
            end
`endif
            default: exec_err = 1'b1;
        endcase
    end

    // Operand capture, iteration counter, divider steps and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= OP_NOP;
            cnt    <= '0;
            result <= '0;
            err    <= 1'b0;
`ifdef TINYALU_DIV_EN
            rem_q  <= '0;
`endif
        end else if (accept_cmd) begin
            a_q  <= A;
            b_q  <= B;
            op_q <= op;
            cnt  <= cnt_load;
`ifdef TINYALU_DIV_EN
            rem_q <= '0;
`endif
        end else if (clear_cmd) begin
            result <= '0;
            err    <= 1'b0;
        end else if (finish) begin
            result <= exec_result;
            err    <= exec_err;
        end else if (state == EXEC) begin
            cnt <= cnt - 1'b1;
`ifdef TINYALU_DIV_EN
            if (op_q == OP_DIV) begin
                rem_q <= rem_step;
                a_q   <= {a_q[WIDTH-2:0], trial_ge};
            end
`endif
        end
    end

endmodule
